// File: rtl/merge_pass_scheduler.sv
// Top-level sort-flow sequencer: runs the sort phase, then issues merge jobs pass by pass
// (run width doubling, ping/pong swapping) until one sorted run remains.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif

module merge_pass_scheduler #(
  parameter int unsigned ADDR_WIDTH      = `BANK_ADDR_WIDTH,
  parameter int unsigned INIT_RUN        = 16,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] stream_len,
  output logic                  sort_en,
  input  logic                  sort_done,
  output logic                  job_valid,
  input  logic                  job_ready,
  input  logic                  job_done,
  output logic [ADDR_WIDTH-1:0] job_a_base,
  output logic [ADDR_WIDTH:0]   job_a_len,
  output logic [ADDR_WIDTH-1:0] job_b_base,
  output logic [ADDR_WIDTH:0]   job_b_len,
  output logic [ADDR_WIDTH-1:0] job_dst_base,
  output logic                  src_bank,
  output logic [5:0]            pass_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  final_bank,
  output logic                  err
);

  localparam int unsigned W  = ADDR_WIDTH + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [W-1:0]  InitRun = W'(INIT_RUN);
  localparam logic [OW-1:0] MaxOut  = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSort,
    StCheck,
    StIssue,
    StDrain,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    len_q, len_d;
  logic [W-1:0]    run_q, run_d;
  logic [W-1:0]    cursor_q, cursor_d;
  logic [OW-1:0]   out_q, out_d;
  logic            src_bank_q, src_bank_d;
  logic [5:0]      pass_idx_q, pass_idx_d;
  logic            final_bank_q, final_bank_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sort_en_q, sort_en_d;
  logic            job_valid_q, job_valid_d;
  logic [ADDR_WIDTH-1:0] job_a_base_q, job_a_base_d;
  logic [ADDR_WIDTH-1:0] job_b_base_q, job_b_base_d;
  logic [W-1:0]    job_a_len_q, job_a_len_d;
  logic [W-1:0]    job_b_len_q, job_b_len_d;

  logic            accept;
  logic            done_ok;
  logic [W-1:0]    run_dbl;
  logic [W-1:0]    rem_a, a_len, b_base, rem_b, b_len;

  assign accept  = (state_q == StIssue) && job_valid_q && job_ready;
  assign done_ok = job_done && (out_q != '0);
  // Saturate at 2^ADDR_WIDTH, the top bit of the W-bit run register.
  assign run_dbl = run_q[W-1] ? run_q : (run_q << 1);

  always_comb begin
    out_d = out_q;
    if (accept && !done_ok) begin
      out_d = out_q + OW'(1);
    end else if (!accept && done_ok) begin
      out_d = out_q - OW'(1);
    end
    err_d = err_q | (job_done && (out_q == '0));
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    run_d        = run_q;
    cursor_d     = cursor_q;
    src_bank_d   = src_bank_q;
    pass_idx_d   = pass_idx_q;
    final_bank_d = final_bank_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          len_d = {1'b0, stream_len};
          if (stream_len == '0) begin
            final_bank_d = 1'b0;
            state_d      = StDone;
          end else begin
            state_d = StWaitSort;
          end
        end
      end
      StWaitSort: begin
        if (sort_done) begin
          src_bank_d = 1'b1;
          run_d      = InitRun;
          cursor_d   = '0;
          pass_idx_d = '0;
          state_d    = StCheck;
        end
      end
      StCheck: begin
        if (run_q >= len_q) begin
          final_bank_d = src_bank_q;
          state_d      = StDone;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (accept) begin
          // run < len here, so cursor + 2*run fits in W bits.
          cursor_d = cursor_q + (run_q << 1);
          if (cursor_d >= len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_q == '0) begin
          src_bank_d = ~src_bank_q;
          run_d      = run_dbl;
          pass_idx_d = pass_idx_q + 6'd1;
          cursor_d   = '0;
          state_d    = StCheck;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Job fields for the pair starting at the (next) cursor.
  always_comb begin
    rem_a  = len_d - cursor_d;
    a_len  = (run_d < rem_a) ? run_d : rem_a;
    b_base = cursor_d + a_len;
    rem_b  = len_d - b_base;
    if (b_base >= len_d) begin
      b_len = '0;
    end else begin
      b_len = (run_d < rem_b) ? run_d : rem_b;
    end
  end

  always_comb begin
    busy_d      = (state_d == StWaitSort) || (state_d == StCheck) ||
                  (state_d == StIssue) || (state_d == StDrain);
    done_d      = (state_d == StDone);
    sort_en_d   = (state_d == StWaitSort);
    job_valid_d = (state_d == StIssue) && (out_d < MaxOut);
    job_a_base_d = '0;
    job_a_len_d  = '0;
    job_b_base_d = '0;
    job_b_len_d  = '0;
    if (state_d == StIssue) begin
      job_a_base_d = cursor_d[ADDR_WIDTH-1:0];
      job_a_len_d  = a_len;
      job_b_base_d = b_base[ADDR_WIDTH-1:0];
      job_b_len_d  = b_len;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      run_q        <= InitRun;
      cursor_q     <= '0;
      out_q        <= '0;
      src_bank_q   <= 1'b0;
      pass_idx_q   <= '0;
      final_bank_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sort_en_q    <= 1'b0;
      job_valid_q  <= 1'b0;
      job_a_base_q <= '0;
      job_a_len_q  <= '0;
      job_b_base_q <= '0;
      job_b_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      run_q        <= run_d;
      cursor_q     <= cursor_d;
      out_q        <= out_d;
      src_bank_q   <= src_bank_d;
      pass_idx_q   <= pass_idx_d;
      final_bank_q <= final_bank_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sort_en_q    <= sort_en_d;
      job_valid_q  <= job_valid_d;
      job_a_base_q <= job_a_base_d;
      job_a_len_q  <= job_a_len_d;
      job_b_base_q <= job_b_base_d;
      job_b_len_q  <= job_b_len_d;
    end
  end

  assign sort_en      = sort_en_q;
  assign job_valid    = job_valid_q;
  assign job_a_base   = job_a_base_q;
  assign job_a_len    = job_a_len_q;
  assign job_b_base   = job_b_base_q;
  assign job_b_len    = job_b_len_q;
  assign job_dst_base = job_a_base_q;
  assign src_bank     = src_bank_q;
  assign pass_idx     = pass_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign final_bank   = final_bank_q;
  assign err          = err_q;

endmodule

// File: tb/tb_merge_pass_scheduler.sv
// Bench for merge_pass_scheduler: table-driven and randomized sorts against a run-pairing
// model, plus directed stall, reset and error sequences.
module tb_merge_pass_scheduler;
  localparam int AW = 10;

  logic          clock, reset, start, sort_en, sort_done, job_valid, job_ready, job_done;
  logic [AW-1:0] stream_len, job_a_base, job_b_base, job_dst_base;
  logic [AW:0]   job_a_len, job_b_len;
  logic          src_bank, busy, done, final_bank, err;
  logic [5:0]    pass_idx;

  typedef struct {int a_base; int a_len; int b_base; int b_len; int src; int pass;} job_t;
  typedef struct {int len; int rdy_pct; int max_dly; int exp_final; int exp_pass;
                  int exp_njobs;} vec_t;

  int    total, bad;
  job_t  exp_q[$];
  int    m_final, m_pass;
  vec_t  tbl[7];
  vec_t  rv;

  merge_pass_scheduler #(.ADDR_WIDTH(AW), .INIT_RUN(16), .MAX_OUTSTANDING(2)) dut (
    .clock(clock), .reset(reset), .start(start), .stream_len(stream_len),
    .sort_en(sort_en), .sort_done(sort_done), .job_valid(job_valid), .job_ready(job_ready),
    .job_done(job_done), .job_a_base(job_a_base), .job_a_len(job_a_len),
    .job_b_base(job_b_base), .job_b_len(job_b_len), .job_dst_base(job_dst_base),
    .src_bank(src_bank), .pass_idx(pass_idx), .busy(busy), .done(done),
    .final_bank(final_bank), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Each pass splits the stream into runs of width `run` and pairs run 2k with run 2k+1.
  task automatic build_model(input int len);
    int run, src, p, nruns;
    exp_q.delete();
    run = 16; src = 1; p = 0;
    while (run < len) begin
      nruns = (len + run - 1) / run;
      for (int k = 0; k < (nruns + 1) / 2; k++) begin
        job_t j;
        j.a_base = 2 * k * run;
        j.a_len  = imin(run, len - j.a_base);
        j.b_base = imin((2 * k + 1) * run, len);
        j.b_len  = imin(run, len - j.b_base);
        j.src    = src;
        j.pass   = p;
        exp_q.push_back(j);
      end
      src = 1 - src; run = run * 2; p++;
    end
    m_final = src; m_pass = p;
  endtask

  task automatic run_sort(input vec_t v);
    int   due_q[$];
    job_t want;
    logic pv, pr, pd;
    int   accepted, bout, sd_at, sort_wait;
    bit   finished;
    build_model(v.len);
    accepted = 0; bout = 0; sd_at = -1; sort_wait = $urandom_range(0, 3); finished = 0;
    pv = 0; pr = 0; pd = 0;
    start = 1; stream_len = AW'(v.len);
    step();
    start = 0;
    chk("busy_rise", busy, 1);
    for (int c = 0; c < 6000 && !finished; c++) begin
      if (pv && pr) begin
        if (exp_q.size() > 0) exp_q.delete(0);
        accepted++; bout++;
        due_q.push_back(c + int'($urandom_range(0, v.max_dly)));
      end
      if (pd) bout--;
      if (pv && !pr) chk("valid_hold", job_valid, 1);
      if (job_valid) begin
        if (exp_q.size() > 0) want = exp_q[0];
        else want = '{default: -1};
        chk("a_base", job_a_base, want.a_base);
        chk("a_len", job_a_len, want.a_len);
        chk("b_base", job_b_base, want.b_base);
        chk("b_len", job_b_len, want.b_len);
        chk("dst_base", job_dst_base, want.a_base);
        chk("src_bank", src_bank, want.src);
        chk("pass_idx", pass_idx, want.pass);
        chk("outstanding_cap", bout < 2, 1);
      end
      if (sd_at >= 0 && c == sd_at + 1) chk("check_gap", {job_valid, done, sort_en}, 0);
      if (sd_at >= 0 && c == sd_at + 2) begin
        if (v.exp_njobs > 0) chk("first_job_lat", job_valid, 1);
        else chk("short_done_lat", done, 1);
      end
      if (done) begin
        chk("final_bank", final_bank, v.exp_final);
        chk("pass_idx_end", pass_idx, v.exp_pass);
        chk("busy_at_done", busy, 0);
        chk("job_count", accepted, v.exp_njobs);
        chk("err_clean", err, 0);
        finished = 1;
      end else begin
        sort_done = 0;
        if (sort_en && sd_at < 0) begin
          if (sort_wait == 0) begin
            sort_done = 1; sd_at = c;
          end else begin
            sort_wait--;
          end
        end
        job_done = 0;
        if (due_q.size() > 0 && due_q[0] <= c) begin
          due_q.delete(0);
          job_done = 1;
        end
        pd = job_done;
        start = ($urandom_range(0, 15) == 0);
        if (start) stream_len = AW'($urandom_range(0, 1023));
        job_ready = ($urandom_range(0, 99) < v.rdy_pct);
        pv = job_valid; pr = job_ready;
        step();
      end
    end
    chk("timeout", finished, 1);
    start = 0; sort_done = 0; job_ready = 0; job_done = 0;
    step();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 0; start = 0; stream_len = '0; sort_done = 0; job_ready = 0; job_done = 0;
    tbl[0] = '{64, 100, 0, 1, 2, 3};
    tbl[1] = '{40, 60, 3, 1, 2, 3};
    tbl[2] = '{100, 50, 4, 0, 3, 7};
    tbl[3] = '{17, 80, 2, 0, 1, 1};
    tbl[4] = '{1023, 70, 5, 1, 6, 63};
    tbl[5] = '{32, 100, 0, 0, 1, 1};
    tbl[6] = '{16, 100, 0, 1, 0, 0};

    step(); step();
    chk("rst_outputs", {busy, done, job_valid, sort_en, err, final_bank, src_bank}, 0);
    chk("rst_pass_idx", pass_idx, 0);
    chk("rst_job_len", {job_a_len, job_b_len}, 0);
    @(negedge clock);
    reset = 1;
    step();
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) run_sort(tbl[i]);

    // Zero-length stream: no sort, done on the very next cycle.
    start = 1; stream_len = '0;
    step();
    start = 0;
    chk("len0_done", done, 1);
    chk("len0_busy_sort", {busy, sort_en}, 0);
    chk("len0_final", final_bank, 0);
    step();
    chk("len0_pulse", {done, sort_en}, 0);

    for (int r = 0; r < 12; r++) begin
      rv.len = $urandom_range(1, 300);
      build_model(rv.len);
      rv.exp_final = m_final; rv.exp_pass = m_pass; rv.exp_njobs = exp_q.size();
      rv.rdy_pct = $urandom_range(30, 100); rv.max_dly = $urandom_range(0, 6);
      run_sort(rv);
    end

    // Stall and outstanding-limit sequence, len=128.
    start = 1; stream_len = AW'(128);
    step();
    start = 0;
    for (int i = 0; i < 5 && !sort_en; i++) step();
    chk("st_sort_en", sort_en, 1);
    sort_done = 1;
    step();
    sort_done = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("st_valid", job_valid, 1);
      chk("st_fields", {job_a_base, job_b_base}, (0 << 10) | 16);
      chk("st_lens", {job_a_len, job_b_len}, (16 << 11) | 16);
      step();
    end
    job_ready = 1;
    step();
    chk("st_job1", {job_valid, job_a_base, job_b_base}, (1 << 20) | (32 << 10) | 48);
    step();
    chk("st_full", job_valid, 0);
    step();
    chk("st_full2", job_valid, 0);
    step();
    chk("st_full3", job_valid, 0);
    job_done = 1;
    step();
    chk("st_reopen", {job_valid, job_a_base}, (1 << 10) | 64);
    step();
    chk("st_simul", {job_valid, job_a_base, job_b_len}, (1 << 21) | (96 << 11) | 16);
    job_done = 0;
    step();
    chk("st_drain", job_valid, 0);
    job_ready = 0; job_done = 1;
    step();
    step();
    job_done = 0;
    for (int i = 0; i < 8 && !job_valid; i++) step();
    chk("p1_valid", job_valid, 1);
    chk("p1_bank_pass", {src_bank, pass_idx}, 1);
    chk("p1_fields", {job_a_base, job_b_base}, (0 << 10) | 32);
    chk("p1_lens", {job_a_len, job_b_len}, (32 << 11) | 32);
    chk("p1_err", err, 0);
    #2;
    reset = 0;
    #1;
    chk("arst_drop", {job_valid, busy, sort_en}, 0);
    chk("arst_pass", pass_idx, 0);
    @(negedge clock);
    reset = 1;
    step();

    rv = '{32, 100, 0, 0, 1, 1};
    run_sort(rv);

    job_done = 1;
    step();
    job_done = 0;
    chk("spurious_err", err, 1);
    step();
    chk("err_sticky", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
